// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the counter and the standalone decoder.
package gray_pkg;

  localparam int GRAY_WIDTH_MIN = 2;
  localparam int GRAY_WIDTH_MAX = 16;

  typedef logic [GRAY_WIDTH_MAX-1:0] gray_word_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } cnt_op_t;

  // Narrower callers zero-extend; zero upper bits leave the low bits of either result unchanged.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
    for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter; usable on its own or inside gray_counter.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_bad_width
    $error("gray_to_bin: WIDTH must be within 2..16");
  end

  assign o_bin = WIDTH'(gray2bin(GRAY_WIDTH_MAX'(i_gray)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray mirror and wrap pulse, plus an
// independent one-cycle Gray-to-binary decoder path.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  input  logic             cv_valid_i,
  input  logic [WIDTH-1:0] cv_gray_i,
  output logic             cv_valid_o,
  output logic [WIDTH-1:0] cv_bin_o
);

  if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_bad_width
    $error("gray_counter: WIDTH must be within 2..16");
  end

  localparam logic [WIDTH-1:0] L_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] L_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] L_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_bin, r_gray, r_cv_bin;
  logic             r_wrap, r_cv_valid;
  logic [WIDTH-1:0] w_bin_next, w_gray_next, w_dec_bin;
  logic             w_wrap_next;
  cnt_op_t          w_op;

  always_comb begin
    if (load) begin
      w_op = OP_LOAD;
    end else if (en) begin
      w_op = up_dn ? OP_UP : OP_DOWN;
    end else begin
      w_op = OP_HOLD;
    end
  end

  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    case (w_op)
      OP_LOAD: w_bin_next = load_val;
      OP_UP: begin
        w_bin_next  = r_bin + L_ONE;
        w_wrap_next = (r_bin == L_ONES);
      end
      OP_DOWN: begin
        w_bin_next  = r_bin - L_ONE;
        w_wrap_next = (r_bin == L_ZERO);
      end
      OP_HOLD: w_bin_next = r_bin;
      default: begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
      end
    endcase
  end

  // Gray is encoded from the next binary value so both registers always agree.
  assign w_gray_next = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(w_bin_next)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= L_ZERO;
      r_gray <= L_ZERO;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_gray_to_bin (
    .i_gray (cv_gray_i),
    .o_bin  (w_dec_bin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cv_valid <= 1'b0;
      r_cv_bin   <= L_ZERO;
    end else begin
      r_cv_valid <= cv_valid_i;
      if (cv_valid_i) begin
        r_cv_bin <= w_dec_bin;
      end else begin
        r_cv_bin <= r_cv_bin;
      end
    end
  end

  assign bin        = r_bin;
  assign gray       = r_gray;
  assign wrap       = r_wrap;
  assign cv_valid_o = r_cv_valid;
  assign cv_bin_o   = r_cv_bin;

endmodule
